// File: rtl/fft4_stream_ctrl.sv
// Streaming sequencer for the fft4 core: gathers four samples, fires the core, replays its bins.
// Optional WAIT watchdog compiled in with FFT4_CTRL_WATCHDOG_EN.
module fft4_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_WIDTH-1:0]       s_real,
  input  logic [DATA_WIDTH-1:0]       s_imag,
  output logic                        core_en,
  output logic [4*DATA_WIDTH-1:0]     core_in_real,
  output logic [4*DATA_WIDTH-1:0]     core_in_imag,
  input  logic                        core_valid,
  input  logic [4*(DATA_WIDTH+2)-1:0] core_out_real,
  input  logic [4*(DATA_WIDTH+2)-1:0] core_out_imag,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH+1:0]       m_real,
  output logic [DATA_WIDTH+1:0]       m_imag,
  output logic [1:0]                  m_index,
  output logic                        m_last,
  output logic                        busy,
  output logic                        err
);

  // state | meaning
  // FILL  | accepting samples into slots 0..3
  // FIRE  | one-cycle core_en pulse, frame frozen on core_in_*
  // WAIT  | waiting for core_valid, then capture all bins
  // DRAIN | replaying bins 0..3 on the m_* stream
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FIRE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int OW = DATA_WIDTH + 2;

  state_t                       state_q, state_d;
  logic [1:0]                   fill_cnt_q, fill_cnt_d;
  logic [1:0]                   drain_cnt_q, drain_cnt_d;
  logic [3:0][DATA_WIDTH-1:0]   smp_re_q, smp_re_d;
  logic [3:0][DATA_WIDTH-1:0]   smp_im_q, smp_im_d;
  logic [3:0][OW-1:0]           buf_re_q, buf_re_d;
  logic [3:0][OW-1:0]           buf_im_q, buf_im_d;
  logic                         s_hs;
  logic                         m_hs;
  logic                         wd_expire;

`ifdef FFT4_CTRL_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d  = '0;
    wd_expire = 1'b0;
    if (state_q == ST_WAIT) begin
      wd_cnt_d  = wd_cnt_q + WDW'(1);
      // core_valid on the final WAIT cycle still wins over the abort
      wd_expire = !core_valid && (wd_cnt_q == WDW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wd_cnt_q <= '0;
    else     wd_cnt_q <= wd_cnt_d;
  end

  assign err = wd_expire;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign wd_expire      = 1'b0;
  assign err            = 1'b0;
`endif

  assign s_ready = (state_q == ST_FILL) && !rst;
  assign s_hs    = s_valid && s_ready;
  assign m_valid = (state_q == ST_DRAIN);
  assign m_hs    = m_valid && m_ready;

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    smp_re_d    = smp_re_q;
    smp_im_d    = smp_im_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    case (state_q)
      ST_FILL: begin
        if (s_hs) begin
          smp_re_d[fill_cnt_q] = s_real;
          smp_im_d[fill_cnt_q] = s_imag;
          fill_cnt_d           = fill_cnt_q + 2'd1;
          if (fill_cnt_q == 2'd3) state_d = ST_FIRE;
        end
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_valid) begin
          buf_re_d = core_out_real;
          buf_im_d = core_out_imag;
          state_d  = ST_DRAIN;
        end else if (wd_expire) begin
          state_d = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (m_hs) begin
          drain_cnt_d = drain_cnt_q + 2'd1;
          if (drain_cnt_q == 2'd3) state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= 2'd0;
      drain_cnt_q <= 2'd0;
      smp_re_q    <= '0;
      smp_im_q    <= '0;
      buf_re_q    <= '0;
      buf_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      smp_re_q    <= smp_re_d;
      smp_im_q    <= smp_im_d;
      buf_re_q    <= buf_re_d;
      buf_im_q    <= buf_im_d;
    end
  end

  assign core_en      = (state_q == ST_FIRE);
  assign core_in_real = smp_re_q;
  assign core_in_imag = smp_im_q;
  assign m_real       = m_valid ? buf_re_q[drain_cnt_q] : '0;
  assign m_imag       = m_valid ? buf_im_q[drain_cnt_q] : '0;
  assign m_index      = drain_cnt_q;
  assign m_last       = m_valid && (drain_cnt_q == 2'd3);
  assign busy         = (state_q != ST_FILL) || (fill_cnt_q != 2'd0);

endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Randomized bench for fft4_stream_ctrl with a behavioural fft4 core of programmable latency.
module tb_fft4_stream_ctrl;
  localparam int DW = 8;
  localparam int OW = DW + 2;
  localparam int TO = 16;

  logic            clk = 1'b0, rst = 1'b1;
  logic            s_valid = 1'b0, s_ready;
  logic [DW-1:0]   s_real = '0, s_imag = '0;
  logic            core_en, core_valid;
  logic [4*DW-1:0] core_in_real, core_in_imag;
  logic [4*OW-1:0] core_or = '0, core_oi = '0;
  logic            m_valid, m_ready = 1'b1, m_last, busy, err;
  logic [OW-1:0]   m_real, m_imag;
  logic [1:0]      m_index;

  fft4_stream_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .core_en(core_en), .core_in_real(core_in_real), .core_in_imag(core_in_imag),
    .core_valid(core_valid), .core_out_real(core_or), .core_out_imag(core_oi),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_index(m_index), .m_last(m_last), .busy(busy), .err(err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  function automatic void fft4(input int xr[4], input int xi[4], output int yr[4], output int yi[4]);
    yr[0] = xr[0] + xr[1] + xr[2] + xr[3];  yi[0] = xi[0] + xi[1] + xi[2] + xi[3];
    yr[1] = xr[0] + xi[1] - xr[2] - xi[3];  yi[1] = xi[0] - xr[1] - xi[2] + xr[3];
    yr[2] = xr[0] - xr[1] + xr[2] - xr[3];  yi[2] = xi[0] - xi[1] + xi[2] - xi[3];
    yr[3] = xr[0] - xi[1] - xr[2] + xi[3];  yi[3] = xi[0] + xr[1] - xi[2] - xr[3];
  endfunction

  // behavioural core: results valid core_lat cycles after the enable cycle
  int   core_lat = 2, core_dly = 0;
  logic core_mute = 1'b0, core_spur = 1'b0;
  always @(posedge clk) begin
    int xr[4], xi[4], yr[4], yi[4];
    if (core_en && !core_mute) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = int'($signed(core_in_real[k*DW +: DW]));
        xi[k] = int'($signed(core_in_imag[k*DW +: DW]));
      end
      fft4(xr, xi, yr, yi);
      for (int k = 0; k < 4; k++) begin
        core_or[k*OW +: OW] <= yr[k][OW-1:0];
        core_oi[k*OW +: OW] <= yi[k][OW-1:0];
      end
      core_dly <= core_lat;
    end else if (core_dly > 0) begin
      core_dly <= core_dly - 1;
    end
  end
  assign core_valid = (core_dly == 1) || core_spur;

  int in_re[$], in_im[$], ex_re[$], ex_im[$];
  int ob_re[$], ob_im[$], ob_idx[$], ob_last[$], ob_cyc[$], hs4_q[$], mv_q[$];
  int en_cnt, en_dbl, cin_bad, hold_bad, srdy_bad, stall_cyc, err_cnt, tmo;

  task automatic rand_frames(input int nfr);
    in_re.delete(); in_im.delete();
    for (int i = 0; i < 4*nfr; i++) begin
      in_re.push_back(int'($urandom_range(0, 255)) - 128);
      in_im.push_back(int'($urandom_range(0, 255)) - 128);
    end
  endtask

  function automatic void build_exp();
    int xr[4], xi[4], yr[4], yi[4];
    ex_re.delete(); ex_im.delete();
    for (int f = 0; f < in_re.size()/4; f++) begin
      for (int k = 0; k < 4; k++) begin xr[k] = in_re[4*f+k]; xi[k] = in_im[4*f+k]; end
      fft4(xr, xi, yr, yi);
      for (int k = 0; k < 4; k++) begin ex_re.push_back(yr[k]); ex_im.push_back(yi[k]); end
    end
  endfunction

  task automatic xfer(input int nfr, input int gap, input int stall_bin, input int stall_len,
                      input int spur_at, input int want);
    int sent = 0, got = 0, guard = 0, stall_rem = stall_len, fe = 0;
    bit tog = 1'b1, hs_prev = 1'b0, prev_en = 1'b0, in_frame = 1'b0, await_mv = 1'b0;
    bit holding = 1'b0, spur_done = 1'b0;
    logic [OW-1:0] h_re = '0, h_im = '0;
    logic [1:0] h_idx = '0;
    ob_re.delete(); ob_im.delete(); ob_idx.delete(); ob_last.delete(); ob_cyc.delete();
    hs4_q.delete(); mv_q.delete();
    en_cnt = 0; en_dbl = 0; cin_bad = 0; hold_bad = 0; srdy_bad = 0; stall_cyc = 0;
    err_cnt = 0; tmo = 0;
    while (sent < 4*nfr || got < want) begin
      if (guard > 400) begin tmo = 1; break; end
      guard++;
      @(negedge clk);
      if (!(s_valid && !hs_prev)) begin
        if (sent < 4*nfr) begin
          s_valid = (gap != 0) ? tog : 1'b1;
          tog     = ~tog;
          s_real  = DW'(in_re[sent]);
          s_imag  = DW'(in_im[sent]);
        end else begin
          s_valid = 1'b0;
        end
      end
      core_spur = 1'b0;
      if (spur_at >= 0 && !spur_done && sent == spur_at) begin core_spur = 1'b1; spur_done = 1'b1; end
      if (m_valid && int'(m_index) == stall_bin && stall_rem > 0) begin
        m_ready = 1'b0; stall_rem--; stall_cyc++;
      end else begin
        m_ready = 1'b1;
      end
      #1;
      if (err) err_cnt++;
      if (core_en) begin
        en_cnt++;
        if (prev_en) en_dbl++;
        for (int k = 0; k < 4; k++)
          if (4*fe+k >= in_re.size() ||
              int'($signed(core_in_real[k*DW +: DW])) != in_re[4*fe+k] ||
              int'($signed(core_in_imag[k*DW +: DW])) != in_im[4*fe+k]) cin_bad++;
        fe++;
      end
      prev_en = core_en;
      if (in_frame && s_ready) srdy_bad++;
      if (await_mv && m_valid) begin mv_q.push_back(cyc); await_mv = 1'b0; end
      if (m_valid) begin
        if (!holding) begin h_re = m_real; h_im = m_imag; h_idx = m_index; holding = 1'b1; end
        else if (m_real !== h_re || m_imag !== h_im || m_index !== h_idx) hold_bad++;
      end
      hs_prev = s_valid && s_ready;
      if (hs_prev) begin
        sent++;
        if (sent % 4 == 0) begin hs4_q.push_back(cyc); in_frame = 1'b1; await_mv = 1'b1; end
      end
      if (m_valid && m_ready) begin
        ob_re.push_back(int'($signed(m_real))); ob_im.push_back(int'($signed(m_imag)));
        ob_idx.push_back(int'(m_index)); ob_last.push_back(int'(m_last)); ob_cyc.push_back(cyc);
        got++; holding = 1'b0;
        if (m_last) in_frame = 1'b0;
      end
    end
    core_spur = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready_in_rst got=%b exp=0", s_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if ({core_en, m_valid, m_last, err, busy} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {core_en, m_valid, m_last, err, busy}); end
    checks++; if (m_index !== 2'd0) begin failures++; $display("FAIL reset_m_index got=%0d exp=0", m_index); end
    checks++; if ({m_real, m_imag} !== '0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", {m_real, m_imag}); end
    checks++; if ({core_in_real, core_in_imag} !== '0) begin failures++; $display("FAIL reset_core_in got=%h exp=0", {core_in_real, core_in_imag}); end
  endtask

  task automatic test_dc();
    in_re = '{1, 1, 1, 1}; in_im = '{0, 0, 0, 0};
    build_exp();
    xfer(1, 0, -1, 0, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4) begin failures++; $display("FAIL dc_beats got=%0d exp=4 tmo=%0d", ob_re.size(), tmo); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k]) begin failures++; $display("FAIL dc_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", k, ob_re[k], ob_im[k], ex_re[k], ex_im[k]); end
      checks++; if (ob_idx[k] != k || ob_last[k] != ((k == 3) ? 1 : 0)) begin failures++; $display("FAIL dc_idx_last%0d got=%0d/%0d exp=%0d/%0d", k, ob_idx[k], ob_last[k], k, (k == 3) ? 1 : 0); end
    end
    if (ob_re.size() > 0) begin
      checks++; if (ob_re[0] != 4 || ob_im[0] != 0) begin failures++; $display("FAIL dc_bin0_const got=(%0d,%0d) exp=(4,0)", ob_re[0], ob_im[0]); end
    end
    if (mv_q.size() > 0 && hs4_q.size() > 0) begin
      checks++; if (mv_q[0] - hs4_q[0] != 4) begin failures++; $display("FAIL dc_latency got=%0d exp=4", mv_q[0] - hs4_q[0]); end
    end
    if (ob_cyc.size() == 4) begin
      checks++; if (ob_cyc[3] - ob_cyc[0] != 3) begin failures++; $display("FAIL dc_drain_len got=%0d exp=3", ob_cyc[3] - ob_cyc[0]); end
    end
    checks++; if (en_cnt != 1 || en_dbl != 0 || cin_bad != 0) begin failures++; $display("FAIL dc_core_en got=%0d/%0d/%0d exp=1/0/0", en_cnt, en_dbl, cin_bad); end
  endtask

  task automatic test_impulse();
    in_re = '{5, 0, 0, 0}; in_im = '{-3, 0, 0, 0};
    xfer(1, 0, -1, 0, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4) begin failures++; $display("FAIL imp_beats got=%0d exp=4", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != 5 || ob_im[k] != -3) begin failures++; $display("FAIL imp_bin%0d got=(%0d,%0d) exp=(5,-3)", k, ob_re[k], ob_im[k]); end
    end
    checks++; if (en_cnt != 1 || en_dbl != 0) begin failures++; $display("FAIL imp_core_en got=%0d/%0d exp=1/0", en_cnt, en_dbl); end
  endtask

  task automatic test_backpressure();
    rand_frames(1); build_exp();
    xfer(1, 0, 1, 3, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4) begin failures++; $display("FAIL bp_beats got=%0d exp=4", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k] || ob_idx[k] != k) begin failures++; $display("FAIL bp_bin%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", k, ob_re[k], ob_im[k], ob_idx[k], ex_re[k], ex_im[k], k); end
    end
    checks++; if (stall_cyc != 3 || hold_bad != 0) begin failures++; $display("FAIL bp_hold got=%0d/%0d exp=3/0", stall_cyc, hold_bad); end
    if (ob_cyc.size() == 4) begin
      checks++; if (ob_cyc[1] - ob_cyc[0] != 4) begin failures++; $display("FAIL bp_stall_len got=%0d exp=4", ob_cyc[1] - ob_cyc[0]); end
    end
    checks++; if (srdy_bad != 0) begin failures++; $display("FAIL bp_s_ready got=%0d exp=0", srdy_bad); end
  endtask

  task automatic test_back_to_back();
    rand_frames(2); build_exp();
    xfer(2, 0, -1, 0, -1, 8);
    checks++; if (tmo != 0 || ob_re.size() != 8) begin failures++; $display("FAIL b2b_beats got=%0d exp=8", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 8; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k] || ob_idx[k] != k % 4) begin failures++; $display("FAIL b2b_beat%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", k, ob_re[k], ob_im[k], ob_idx[k], ex_re[k], ex_im[k], k % 4); end
    end
    if (ob_cyc.size() == 8 && hs4_q.size() == 2) begin
      checks++; if (hs4_q[1] - ob_cyc[3] != 4) begin failures++; $display("FAIL b2b_refill got=%0d exp=4", hs4_q[1] - ob_cyc[3]); end
    end
    checks++; if (en_cnt != 2 || en_dbl != 0 || cin_bad != 0 || srdy_bad != 0) begin failures++; $display("FAIL b2b_ctrl got=%0d/%0d/%0d/%0d exp=2/0/0/0", en_cnt, en_dbl, cin_bad, srdy_bad); end
  endtask

  task automatic test_gaps();
    rand_frames(2); build_exp();
    xfer(2, 1, -1, 0, 2, 8);
    checks++; if (tmo != 0 || ob_re.size() != 8) begin failures++; $display("FAIL gap_beats got=%0d exp=8", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 8; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k]) begin failures++; $display("FAIL gap_beat%0d got=(%0d,%0d) exp=(%0d,%0d)", k, ob_re[k], ob_im[k], ex_re[k], ex_im[k]); end
    end
    checks++; if (cin_bad != 0 || en_cnt != 2) begin failures++; $display("FAIL gap_core_in got=%0d/%0d exp=0/2", cin_bad, en_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    rand_frames(1);
    xfer(1, 0, -1, 0, -1, 2);
    @(negedge clk); rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1; #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rmd_s_ready_in_rst got=%b exp=0", s_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({m_valid, m_last, core_en, busy, err} !== 5'b0 || m_index !== 2'd0 || {m_real, m_imag} !== '0) begin failures++; $display("FAIL rmd_outputs got=%b/%0d/%h exp=00000/0/0", {m_valid, m_last, core_en, busy, err}, m_index, {m_real, m_imag}); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rmd_s_ready got=%b exp=1", s_ready); end
    rand_frames(1); build_exp();
    xfer(1, 0, -1, 0, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4) begin failures++; $display("FAIL rmd_next_beats got=%0d exp=4", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k] || ob_idx[k] != k) begin failures++; $display("FAIL rmd_next_bin%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", k, ob_re[k], ob_im[k], ob_idx[k], ex_re[k], ex_im[k], k); end
    end
  endtask

  task automatic test_long_latency();
    core_lat = TO;
    rand_frames(1); build_exp();
    xfer(1, 0, -1, 0, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4 || err_cnt != 0) begin failures++; $display("FAIL lat16_beats got=%0d err=%0d exp=4 err=0", ob_re.size(), err_cnt); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k]) begin failures++; $display("FAIL lat16_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", k, ob_re[k], ob_im[k], ex_re[k], ex_im[k]); end
    end
    if (mv_q.size() > 0 && hs4_q.size() > 0) begin
      checks++; if (mv_q[0] - hs4_q[0] != 2 + TO) begin failures++; $display("FAIL lat16_latency got=%0d exp=%0d", mv_q[0] - hs4_q[0], 2 + TO); end
    end
    core_lat = 2;
  endtask

  task automatic test_watchdog();
    int c0, err_n = 0, err_c = -1, mv_n = 0, sr_after = -1, busy_after = -1;
    core_mute = 1'b1;
    rand_frames(1);
    xfer(1, 0, -1, 0, -1, 0);
    c0 = (hs4_q.size() > 0) ? hs4_q[0] : -1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); s_valid = 1'b0; #1;
      if (err) begin err_n++; err_c = cyc; end
      if (err_c >= 0 && cyc == err_c + 1) begin sr_after = int'(s_ready); busy_after = int'(busy); end
      if (m_valid) mv_n++;
    end
    checks++; if (mv_n != 0) begin failures++; $display("FAIL wd_no_output got=%0d exp=0", mv_n); end
`ifdef FFT4_CTRL_WATCHDOG_EN
    checks++; if (err_n != 1 || err_c != c0 + 1 + TO) begin failures++; $display("FAIL wd_err got=%0d@%0d exp=1@%0d", err_n, err_c, c0 + 1 + TO); end
    checks++; if (sr_after != 1 || busy_after != 0) begin failures++; $display("FAIL wd_refill got=%0d/%0d exp=1/0", sr_after, busy_after); end
`else
    checks++; if (err_n != 0) begin failures++; $display("FAIL wd_err_tied got=%0d exp=0", err_n); end
    checks++; if (s_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wd_stays_wait got=%b/%b exp=0/1", s_ready, busy); end
`endif
    core_mute = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rand_frames(1); build_exp();
    xfer(1, 0, -1, 0, -1, 4);
    checks++; if (tmo != 0 || ob_re.size() != 4) begin failures++; $display("FAIL wd_next_beats got=%0d exp=4", ob_re.size()); end
    for (int k = 0; k < ob_re.size() && k < 4; k++) begin
      checks++; if (ob_re[k] != ex_re[k] || ob_im[k] != ex_im[k]) begin failures++; $display("FAIL wd_next_bin%0d got=(%0d,%0d) exp=(%0d,%0d)", k, ob_re[k], ob_im[k], ex_re[k], ex_im[k]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_dc();
    test_impulse();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_reset_mid_drain();
    test_long_latency();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
